// File: rtl/lsm_neuron_param.sv
// Parametrised LSM reservoir neuron: second-order synaptic currents, sequenced channel scan, refractory firing.
// Define LSM_SPIKE_TRACE_EN to build the postsynaptic trace on post_trace; otherwise it is tied to zero.
module lsm_neuron_param #(
    parameter int N_IN        = 8,
    parameter int N_REC       = 16,
    parameter int W_IN_W      = 4,
    parameter int W_REC_W     = 4,
    parameter int IN_SCALE    = 11,
    parameter int REC_SCALE   = 2,
    parameter int ACC_W       = 32,
    parameter int SH_VM       = 5,
    parameter int SH_EP       = 2,
    parameter int SH_EN       = 3,
    parameter int SH_IP       = 2,
    parameter int SH_IN       = 1,
    parameter int VTH         = 20480,
    parameter int T_REF       = 3,
    parameter int TRACE_SHIFT = 2,
    parameter int TRACE_INC   = 64
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       start,
    input  logic                       clr,
    input  logic [N_IN-1:0]            input_spike,
    input  logic [N_IN*W_IN_W-1:0]     input_weight,
    input  logic [N_REC-1:0]           rec_spike,
    input  logic [N_REC-1:0]           rec_excite,
    input  logic [N_REC*W_REC_W-1:0]   rec_weight,
    output logic                       busy,
    output logic                       done,
    output logic                       curr_spike,
    output logic [ACC_W-1:0]           vmem,
    output logic [7:0]                 post_trace
);
    localparam int EW = ACC_W + 3;
    localparam int DW = ACC_W + 1;
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int RW = (N_REC > 1) ? $clog2(N_REC) : 1;
    localparam int CW = (IW > RW) ? IW : RW;
    localparam int FW = (T_REF > 0) ? $clog2(T_REF + 1) : 1;
    localparam logic [CW-1:0] IN_LAST  = CW'(N_IN - 1);
    localparam logic [CW-1:0] REC_LAST = CW'(N_REC - 1);
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = -SAT_MAX;
    localparam logic signed [ACC_W-1:0] VTH_A = ACC_W'(VTH);
    localparam logic [FW-1:0] T_REF_F = FW'(T_REF);

    typedef enum logic [2:0] {IDLE, LEAK, IN_SCAN, REC_SCAN, INTEG, FIRE} state_t;

    state_t                  state_q;
    logic [CW-1:0]           ch_q;
    logic [FW-1:0]           ref_q;
    logic signed [ACC_W-1:0] vm_q, ep_q, en_q, ip_q, in_q;
    logic                    done_q, spike_q;

    logic [IW-1:0]           in_idx;
    logic [RW-1:0]           rec_idx;
    logic signed [EW-1:0]    in_add, rec_add;
    logic signed [DW-1:0]    dif_e, dif_i;
    logic signed [ACC_W-1:0] vm_int;
    logic                    fire;

    // Symmetric clamp: the most negative code is never produced.
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [EW-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[ACC_W-1:0];
        if (x < SAT_MIN) return SAT_MIN[ACC_W-1:0];
        return x[ACC_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] leak(input logic signed [ACC_W-1:0] x,
                                                     input int unsigned sh);
        return sat(EW'(x) - EW'(x >>> sh));
    endfunction

    always_comb begin
        in_idx  = ch_q[IW-1:0];
        rec_idx = ch_q[RW-1:0];
        in_add  = EW'($signed(input_weight[in_idx*W_IN_W +: W_IN_W])) <<< IN_SCALE;
        rec_add = EW'(rec_weight[rec_idx*W_REC_W +: W_REC_W]) << REC_SCALE;
        dif_e   = DW'(en_q) - DW'(ep_q);
        dif_i   = DW'(ip_q) - DW'(in_q);
        vm_int  = sat(EW'(vm_q) + EW'(dif_e >>> 2) - EW'(dif_i >>> 1));
        fire    = (ref_q == '0) && (vm_q > VTH_A);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            ref_q   <= '0;
            vm_q    <= '0;
            ep_q    <= '0;
            en_q    <= '0;
            ip_q    <= '0;
            in_q    <= '0;
            done_q  <= 1'b0;
            spike_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        vm_q  <= '0;
                        ep_q  <= '0;
                        en_q  <= '0;
                        ip_q  <= '0;
                        in_q  <= '0;
                        ref_q <= '0;
                    end else if (start) begin
                        state_q <= LEAK;
                    end
                end
                LEAK: begin
                    vm_q    <= leak(vm_q, SH_VM);
                    ep_q    <= leak(ep_q, SH_EP);
                    en_q    <= leak(en_q, SH_EN);
                    ip_q    <= leak(ip_q, SH_IP);
                    in_q    <= leak(in_q, SH_IN);
                    ch_q    <= '0;
                    state_q <= IN_SCAN;
                end
                IN_SCAN: begin
                    if (input_spike[in_idx]) begin
                        ep_q <= sat(EW'(ep_q) + in_add);
                        en_q <= sat(EW'(en_q) + in_add);
                    end
                    if (ch_q == IN_LAST) begin
                        ch_q    <= '0;
                        state_q <= REC_SCAN;
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                end
                REC_SCAN: begin
                    if (rec_spike[rec_idx]) begin
                        if (rec_excite[rec_idx]) begin
                            ep_q <= sat(EW'(ep_q) + rec_add);
                            en_q <= sat(EW'(en_q) + rec_add);
                        end else begin
                            ip_q <= sat(EW'(ip_q) + rec_add);
                            in_q <= sat(EW'(in_q) + rec_add);
                        end
                    end
                    if (ch_q == REC_LAST) begin
                        ch_q    <= '0;
                        state_q <= INTEG;
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                end
                INTEG: begin
                    vm_q    <= (ref_q != '0) ? '0 : vm_int;
                    state_q <= FIRE;
                end
                FIRE: begin
                    if (fire) begin
                        spike_q <= 1'b1;
                        vm_q    <= '0;
                        ref_q   <= T_REF_F;
                    end else begin
                        spike_q <= 1'b0;
                        if (ref_q != '0) ref_q <= ref_q - 1'b1;
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign curr_spike = spike_q;
    assign vmem       = vm_q;

`ifdef LSM_SPIKE_TRACE_EN
    logic [7:0]  trace_q;
    int unsigned trace_sum;

    always_comb trace_sum = 32'(trace_q) + 32'(TRACE_INC);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            trace_q <= '0;
        end else begin
            case (state_q)
                IDLE:    if (clr) trace_q <= '0;
                LEAK:    trace_q <= trace_q - (trace_q >> TRACE_SHIFT);
                FIRE:    if (fire) trace_q <= (trace_sum > 32'd255) ? 8'hFF : trace_sum[7:0];
                default: trace_q <= trace_q;
            endcase
        end
    end

    assign post_trace = trace_q;
`else
    assign post_trace = '0;
`endif

endmodule

// File: doc/lsm_neuron_param.md
Name: lsm_neuron_param

Overview:
- Parametrised liquid-state-machine reservoir neuron with second-order synaptic response. It is the successor to the fixed 8-input / 16-recurrent neuron.
- Channel counts, weight widths, scales, leak shifts, threshold and refractory period are all parameters.
- An internal sequencer replaces the externally driven state/cnt buses. Recurrent inhibitory synapses are now functional.
- One instance per reservoir neuron. The reservoir controller pulses start once per time step and collects curr_spike on done.

Parameters:
- N_IN, 8, number of input channels
- N_REC, 16, number of recurrent channels
- W_IN_W, 4, input weight width (signed, two's complement)
- W_REC_W, 4, recurrent weight width (unsigned magnitude)
- IN_SCALE, 11, left shift applied to input weight
- REC_SCALE, 2, left shift applied to recurrent weight
- ACC_W, 32, width of Vmem/EP/EN/IP/IN (signed)
- SH_VM, 5; SH_EP, 2; SH_EN, 3; SH_IP, 2; SH_IN, 1, leak shifts
- VTH, 20480, firing threshold (strict greater-than)
- T_REF, 3, refractory time steps
- TRACE_SHIFT, 2; TRACE_INC, 64, trace parameters (used only with the optional feature)

Ports:
- Clk, input, 1, clock
- Rst, input, 1, synchronous active-high reset
- start, input, 1, begin one time step (sampled only in IDLE)
- clr, input, 1, clear neuron dynamics (honoured only in IDLE)
- input_spike, input, N_IN, input spike bits; channel i = bit i
- input_weight, input, N_IN*W_IN_W, signed weights; channel i = slice [i*W_IN_W +: W_IN_W]
- rec_spike, input, N_REC, previous-step reservoir spikes
- rec_excite, input, N_REC, 1 = excitatory, 0 = inhibitory
- rec_weight, input, N_REC*W_REC_W, magnitudes, same slicing rule
- busy, output, 1, high outside IDLE
- done, output, 1, one-cycle pulse at end of step
- curr_spike, output, 1, spike result of the last completed step
- vmem, output, ACC_W, current Vmem
- post_trace, output, 8, postsynaptic trace (optional feature)

Behaviour:
- Rst (sync, active-high): state=IDLE; Vmem, EP, EN, IP, IN, ref_cnt, ch_cnt=0; busy, done, curr_spike=0; post_trace=0. Rst overrides a step in progress; the step is aborted and no done is produced.
- IDLE:
  - clr=1: zero Vmem, EP, EN, IP, IN, ref_cnt, post_trace; stay in IDLE. clr has priority over start.
  - start=1: go to LEAK.
  - start while busy is ignored.
- LEAK (1 cycle): X <= X - (X>>>SH_X) for each accumulator (arithmetic shift). ch_cnt=0. Go to IN_SCAN.
- IN_SCAN (N_IN cycles): if input_spike[ch_cnt], EP and EN += sign_extend(w)<<<IN_SCALE. ch_cnt wraps to 0 after N_IN-1, then go to REC_SCAN.
- REC_SCAN (N_REC cycles): if rec_spike[ch_cnt]:
  - excitatory: EP and EN += w<<REC_SCALE
  - inhibitory: IP and IN += w<<REC_SCALE
  - After ch_cnt = N_REC-1, go to INTEG.
- INTEG (1 cycle):
  - ref_cnt>0: Vmem <= 0.
  - Otherwise: Vmem <= Vmem + ((EN-EP)>>>2) - ((IP-IN)>>>1). Inhibition lowers Vmem.
  - Go to FIRE.
- FIRE (1 cycle):
  - If ref_cnt==0 and Vmem > VTH: curr_spike <= 1, Vmem <= 0, ref_cnt <= T_REF.
  - Else: curr_spike <= 0, and ref_cnt decrements if nonzero.
  - done <= 1 for this one cycle. Go to IDLE.
- Latency: done is high in the cycle after edge N_IN+N_REC+4, counted from the edge that samples start. Step-to-step minimum spacing is N_IN+N_REC+4 cycles. start may be asserted in the same cycle done is high.
- Arithmetic: all additions saturate to ±(2^(ACC_W-1)-1) and never wrap. Intermediate differences are computed at ACC_W+1 bits before shifting.
- Spike inputs and weights are read live during the scan and must be held stable while busy=1.
- curr_spike holds its value until the next FIRE.

Optional Feature:
- Macro: LSM_SPIKE_TRACE_EN.
- Defined:
  - post_trace decays in LEAK: t <= t - (t>>TRACE_SHIFT).
  - On a FIRE that produces a spike: t <= min(255, t+TRACE_INC).
  - Cleared by Rst and by clr.
  - Intended for the downstream STDP unit.
- Undefined: post_trace is tied to 0 and no trace register is inferred.

Test Plan:
- Rst mid-REC_SCAN -> next cycle busy=0, done never pulses, vmem=0, curr_spike=0.
- Defaults, input channel 0 spiking with w=+4 each step, nothing else -> EP=EN=8192 after step 1; Vmem rises monotonically; curr_spike=1 on first step where Vmem>20480; vmem=0 afterwards.
- After a spike with the same stimulus -> curr_spike=0 for exactly 3 following steps (Vmem held 0), integration resumes on step 4.
- Inhibitory rec channel 5 spiking, w=15, no input -> IP=IN=60 after step 1; Vmem goes negative and curr_spike stays 0.
- Force accumulators near max with w=+7 on all inputs for many steps -> values clamp at 2^31-1, no sign flip.
- With LSM_SPIKE_TRACE_EN defined: spike -> post_trace=64; next non-spiking step -> 48; 4 consecutive spikes -> saturation at 255 never exceeded.
